mc_datapath_hs: RTL and testbench
=================================

Name: mc_datapath_hs

Overview:
Parametrised multicycle MIPS datapath for the next-generation CPU. It keeps the existing PC/NPC/IR/RF/EXT/ALU structure and its external control-strobe contract, and adds configurable data width and register count. Fixed-latency instruction and data memories are replaced by one unified memory port with a req/ack handshake, so the block can stall on slow memory. The external controller FSM drives the strobes and waits on mem_done.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; instruction word is always 32 bits.
NREG, 32, register count; power of two, 8..32.
PC_RESET, 32'h0000_3000, PC value after reset, zero-extended to XLEN.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pc_wr  in  1  load PC from NPC
ir_wr  in  1  load IR from MDR[31:0]
rf_wr  in  1  register-file write enable
npc_op  in  2  00 PC+4, 01 branch, 10 jump, 11 jr
alu_op  in  4  ALU operation code (package constants)
ext_op  in  2  00 zero-ext, 01 sign-ext, 10 lui
b_sel  in  1  ALU B operand: 0 B reg, 1 Imm
d_sel  in  2  RF write data: 00 ALUOut, 01 MDR, 10 PC
r_sel  in  2  RF write address: 00 rt, 01 rd, 10 NREG-1 (link)
mem_rd / mem_wr  in  1 / 1  start a read / write transaction
mem_src  in  1  address source: 0 PC (fetch), 1 ALUOut
mem_req_o  out  1  request valid
mem_we_o  out  1  write qualifier
mem_addr_o  out  XLEN  byte address
mem_wdata_o  out  XLEN  store data (B reg)
mem_ack_i  in  1  memory completion
mem_rdata_i  in  XLEN  read data
mem_busy  out  1  transaction in flight
mem_done  out  1  one-cycle completion pulse
op / funct  out  6 / 6  IR[31:26] / IR[5:0]
zero  out  1  ALU result == 0 (combinational)
pc_o  out  XLEN  current PC

Behaviour:
- Reset values: PC = PC_RESET. IR, A, B, ALUOut, MDR and all RF entries = 0. Memory FSM = IDLE. mem_req_o, mem_we_o, mem_busy and mem_done = 0. mem_addr_o and mem_wdata_o = 0.
- A and B latch the RF outputs at every clock edge. ALUOut latches the ALU result at every clock edge. The controller relies on this one-cycle stage latency.
- RF has two asynchronous read ports and one synchronous write port. Reads of r0 return 0. Writes to r0 are dropped. A same-cycle read of the address being written returns the old value.
- NPC encodings:
  - PC+4.
  - Branch: PC + (sext(imm16) << 2); PC is already incremented.
  - Jump: {PC[XLEN-1:28], IR[25:0], 2'b00}.
  - jr: A.
  - PC updates only when pc_wr = 1.
- EXT (all results XLEN wide):
  - Zero-extend.
  - Sign-extend.
  - lui: imm16 << 16, sign-extended from bit 31.
  - ext_op 11 is treated as zero-extend.
- Memory FSM IDLE -> REQ -> DONE -> IDLE:
  - IDLE: mem_rd or mem_wr moves to REQ on the next edge. At that edge, register the address (mux by mem_src), the write data and the write qualifier; assert mem_req_o and mem_busy.
  - REQ: hold mem_req_o, mem_addr_o, mem_we_o and mem_wdata_o stable until mem_ack_i = 1. On ack, MDR captures mem_rdata_i (reads only), mem_req_o drops, and the FSM moves to DONE.
  - DONE: mem_done = 1 for exactly one cycle; mem_busy stays 1; return to IDLE.
  - mem_rd and mem_wr in the same cycle: the write wins.
  - Strobes arriving outside IDLE are ignored.
  - mem_ack_i outside REQ is ignored.
  - Minimum latency from strobe to mem_done is 2 cycles (ack arriving in the first REQ cycle).
- rst in the middle of a transaction drops the request immediately at that edge; no mem_done is generated.
- Address width: mem_addr_o is always a byte address. Without the optional feature, bits [1:0] (or [2:0] for a 64-bit store/load) pass through unchanged.

Optional Feature:
MC_DP_MISALIGN_EN:
- When defined, adds output mem_err (1 bit).
- A request whose address[1:0] != 0 skips REQ and goes straight to DONE. mem_req_o is never asserted; mem_done and mem_err pulse together; MDR is unchanged.
- When undefined, mem_err does not exist and misaligned addresses are issued as-is.

Decomposition:
- Package mc_dp_pkg holds:
  - alu_op codes;
  - npc_op, ext_op, d_sel and r_sel constants;
  - the memory-FSM state type (IDLE/REQ/DONE);
  - OP/FUNCT field position constants.
- One sub-module, mc_dp_memif, holds the handshake FSM, the registered address/data/we outputs, MDR capture and the optional misalign check.
- The RF and ALU are instantiated as parametrised children (existing style).

Test Plan:
1. Reset check: assert rst for 2 cycles -> pc_o = 0x3000; mem_req_o = 0, mem_busy = 0; op = 0, funct = 0; all RF reads 0.
2. Fetch handshake: mem_rd with mem_src = 0, ack delayed 3 cycles, mem_rdata_i = 0x00221820 -> mem_addr_o = 0x3000 and held stable throughout; mem_done pulses once; after ir_wr, op = 0x00 and funct = 0x20.
3. R-type add: r1 = 5, r2 = 7, alu_op = ADD, b_sel = 0, r_sel = 01, d_sel = 00, rf_wr -> r3 = 12. A repeat with destination r0 leaves r0 = 0.
4. NPC modes from PC = 0x3000:
   - branch with imm = 0xFFFF -> 0x3000;
   - jump with IR[25:0] = 0x0000C01 -> 0x3004;
   - jr with A = 0x3100 -> 0x3100.
5. Contention and abort: mem_rd and mem_wr asserted together -> mem_we_o = 1. A second strobe during REQ is ignored. rst during REQ -> mem_req_o = 0 next cycle and no mem_done.
6. With MC_DP_MISALIGN_EN defined: data read from ALUOut = 0x1002 -> mem_req_o never asserted; mem_err and mem_done pulse in the same cycle; MDR unchanged.

Source files
------------

// File: rtl/mc_dp_pkg.sv
// Shared constants and types for the multicycle MIPS datapath (mc_datapath_hs).
// Declarations only: no timing and no flow control of its own.
package mc_dp_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] D_ALU = 2'b00;
  localparam logic [1:0] D_MDR = 2'b01;
  localparam logic [1:0] D_PC  = 2'b10;

  localparam logic [1:0] R_RT   = 2'b00;
  localparam logic [1:0] R_RD   = 2'b01;
  localparam logic [1:0] R_LINK = 2'b10;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_DONE = 2'd2
  } mem_state_t;

  // Instruction field positions within the 32-bit IR.
  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_LO    = 21;
  localparam int RT_LO    = 16;
  localparam int RD_LO    = 11;
  localparam int SH_HI    = 10;
  localparam int SH_LO    = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int JT_HI    = 25;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [15:0] imm;
  } itype_t;

endpackage

// File: rtl/mc_dp_alu.sv
// Combinational ALU for the multicycle datapath; shifts move operand b by shamt.
// Zero latency; no flow control.
module mc_dp_alu
  import mc_dp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [SHW-1:0]  shamt,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
      ALU_SLL:  y = b << shamt;
      ALU_SRL:  y = b >> shamt;
      ALU_SRA:  y = $signed(b) >>> shamt;
      default:  y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/mc_dp_memif.sv
// Unified memory port: IDLE->REQ->DONE handshake, registered addr/data/we, MDR capture; MC_DP_MISALIGN_EN adds err.
// Strobe to done is 2 cycles minimum; REQ holds until ack, strobes outside IDLE and acks outside REQ are ignored.
module mc_dp_memif
  import mc_dp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd,
  input  logic            wr,
  input  logic            src,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] store,
  input  logic            ack,
  input  logic [XLEN-1:0] rdata,
  output logic            req,
  output logic            we,
  output logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
`ifdef MC_DP_MISALIGN_EN
  output logic            err,
`endif
  output logic [XLEN-1:0] mdr
);

  mem_state_t      state;
  logic [XLEN-1:0] addr_sel;
  logic            start;
  logic            skip;

  assign addr_sel = src ? alu_out : pc;
  assign start    = (state == MS_IDLE) && (rd || wr);

`ifdef MC_DP_MISALIGN_EN
  assign skip = (addr_sel[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= start && skip;
  end
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MS_IDLE;
      req   <= 1'b0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      mdr   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MS_IDLE: begin
          if (start) begin
            addr  <= addr_sel;
            wdata <= store;
            we    <= wr;   // write wins when both strobes arrive together
            busy  <= 1'b1;
            if (skip) begin
              state <= MS_DONE;
              done  <= 1'b1;
            end else begin
              state <= MS_REQ;
              req   <= 1'b1;
            end
          end
        end
        MS_REQ: begin
          if (ack) begin
            req   <= 1'b0;
            done  <= 1'b1;
            state <= MS_DONE;
            if (!we) mdr <= rdata;
          end
        end
        MS_DONE: begin
          busy  <= 1'b0;
          state <= MS_IDLE;
        end
        default: begin
          req   <= 1'b0;
          busy  <= 1'b0;
          state <= MS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/mc_dp_rf.sv
// Register file: two asynchronous read ports, one synchronous write port, r0 hardwired to 0.
// Write lands at the clock edge; a same-cycle read of the written entry sees the old value.
module mc_dp_rf #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/mc_datapath_hs.sv
// Multicycle MIPS datapath (PC/NPC/IR/RF/EXT/ALU) with a req/ack memory port; MC_DP_MISALIGN_EN adds mem_err.
// A/B/ALUOut are one-cycle stages; memory accesses stall the external controller until mem_done.
module mc_datapath_hs
  import mc_dp_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          NREG     = 32,
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_wr,
  input  logic            ir_wr,
  input  logic            rf_wr,
  input  logic [1:0]      npc_op,
  input  logic [3:0]      alu_op,
  input  logic [1:0]      ext_op,
  input  logic            b_sel,
  input  logic [1:0]      d_sel,
  input  logic [1:0]      r_sel,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic            mem_src,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            mem_busy,
  output logic            mem_done,
`ifdef MC_DP_MISALIGN_EN
  output logic            mem_err,
`endif
  output logic [5:0]      op,
  output logic [5:0]      funct,
  output logic            zero,
  output logic [XLEN-1:0] pc_o
);

  localparam int AW  = $clog2(NREG);
  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] pc_q, a_q, b_q, alu_out_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] mdr;
  logic [XLEN-1:0] npc, pc_plus4, imm_ext, br_off;
  logic [XLEN-1:0] alu_b, alu_y;
  logic [XLEN-1:0] rf_rd1, rf_rd2, rf_wdata;
  logic [AW-1:0]   rf_waddr;
  logic [15:0]     imm16;

  assign imm16 = ir_q[IMM_HI:IMM_LO];
  assign op    = ir_q[OP_HI:OP_LO];
  assign funct = ir_q[FUNCT_HI:FUNCT_LO];
  assign pc_o  = pc_q;

  always_comb begin
    imm_ext = XLEN'(imm16);
    case (ext_op)
      EXT_SIGN: imm_ext = XLEN'($signed(imm16));
      EXT_LUI:  imm_ext = XLEN'($signed({imm16, 16'h0000}));
      default:  imm_ext = XLEN'(imm16);
    endcase
  end

  // Branch offsets count from the instruction after the branch.
  assign pc_plus4 = pc_q + XLEN'(4);
  assign br_off   = XLEN'($signed({imm16, 2'b00}));

  always_comb begin
    npc = pc_plus4;
    case (npc_op)
      NPC_BR:  npc = pc_plus4 + br_off;
      NPC_J:   npc = {pc_q[XLEN-1:28], ir_q[JT_HI:0], 2'b00};
      NPC_JR:  npc = a_q;
      default: npc = pc_plus4;
    endcase
  end

  always_comb begin
    rf_waddr = ir_q[RT_LO +: AW];
    case (r_sel)
      R_RD:    rf_waddr = ir_q[RD_LO +: AW];
      R_LINK:  rf_waddr = AW'(NREG - 1);
      default: rf_waddr = ir_q[RT_LO +: AW];
    endcase
  end

  always_comb begin
    rf_wdata = alu_out_q;
    case (d_sel)
      D_MDR:   rf_wdata = mdr;
      D_PC:    rf_wdata = pc_q;
      default: rf_wdata = alu_out_q;
    endcase
  end

  assign alu_b = b_sel ? imm_ext : b_q;

  mc_dp_rf #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_wr),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr1 (ir_q[RS_LO +: AW]),
    .raddr2 (ir_q[RT_LO +: AW]),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  mc_dp_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .op    (alu_op),
    .a     (a_q),
    .b     (alu_b),
    .shamt (SHW'(ir_q[SH_HI:SH_LO])),
    .y     (alu_y),
    .zero  (zero)
  );

  mc_dp_memif #(
    .XLEN (XLEN)
  ) u_memif (
    .clk     (clk),
    .rst     (rst),
    .rd      (mem_rd),
    .wr      (mem_wr),
    .src     (mem_src),
    .pc      (pc_q),
    .alu_out (alu_out_q),
    .store   (b_q),
    .ack     (mem_ack_i),
    .rdata   (mem_rdata_i),
    .req     (mem_req_o),
    .we      (mem_we_o),
    .addr    (mem_addr_o),
    .wdata   (mem_wdata_o),
    .busy    (mem_busy),
    .done    (mem_done),
`ifdef MC_DP_MISALIGN_EN
    .err     (mem_err),
`endif
    .mdr     (mdr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= XLEN'(PC_RESET);
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
    end else begin
      if (pc_wr) pc_q <= npc;
      if (ir_wr) ir_q <= mdr[31:0];
      a_q       <= rf_rd1;
      b_q       <= rf_rd2;
      alu_out_q <= alu_y;
    end
  end

endmodule

// File: tb/tb_mc_datapath_hs.sv
// Randomised self-checking bench for mc_datapath_hs against a behavioural model of PC, IR, MDR and the RF.
module tb_mc_datapath_hs;
  import mc_dp_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, pc_wr, ir_wr, rf_wr, b_sel, mem_rd, mem_wr, mem_src, mem_ack_i;
  logic [1:0]      npc_op, ext_op, d_sel, r_sel;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] mem_rdata_i;
  logic            mem_req_o, mem_we_o, mem_busy, mem_done, zero;
  logic [XLEN-1:0] mem_addr_o, mem_wdata_o, pc_o;
  logic [5:0]      op, funct;
`ifdef MC_DP_MISALIGN_EN
  logic            mem_err;
`endif

  mc_datapath_hs #(.XLEN(XLEN), .NREG(NREG), .PC_RESET(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .pc_wr(pc_wr), .ir_wr(ir_wr), .rf_wr(rf_wr),
    .npc_op(npc_op), .alu_op(alu_op), .ext_op(ext_op), .b_sel(b_sel),
    .d_sel(d_sel), .r_sel(r_sel), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_src(mem_src),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .mem_busy(mem_busy), .mem_done(mem_done),
`ifdef MC_DP_MISALIGN_EN
    .mem_err(mem_err),
`endif
    .op(op), .funct(funct), .zero(zero), .pc_o(pc_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Architectural model
  logic [31:0] m_pc, m_ir, m_mdr;
  logic [31:0] m_rf [32];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_pc  = 32'h0000_3000;
    m_ir  = '0;
    m_mdr = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ext_ref(input logic [15:0] imm, input logic [1:0] e);
    if (e == EXT_SIGN) return {{16{imm[15]}}, imm};
    if (e == EXT_LUI)  return {imm, 16'h0000};
    return {16'h0000, imm};
  endfunction

  // One memory transaction; poke re-asserts both strobes while the request is pending.
  task automatic mem_xact(input bit rd, input bit wr, input bit src, input logic [31:0] rdata,
                          input int delay, input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input bit poke, input string tag);
    mem_rd = rd; mem_wr = wr; mem_src = src;
    tick;
    mem_rd = 1'b0; mem_wr = 1'b0;
    chk({tag, "_req"}, mem_req_o, 1);
    chk({tag, "_busy"}, mem_busy, 1);
    chk({tag, "_addr"}, mem_addr_o, exp_addr);
    chk({tag, "_we"}, mem_we_o, wr);
    if (wr) chk({tag, "_wdata"}, mem_wdata_o, exp_wdata);
    for (int i = 0; i < delay; i++) begin
      if (poke && i == 0) begin mem_rd = 1'b1; mem_wr = 1'b1; end
      tick;
      mem_rd = 1'b0; mem_wr = 1'b0;
      chk({tag, "_hold_addr"}, mem_addr_o, exp_addr);
      chk({tag, "_hold_req"}, mem_req_o, 1);
      chk({tag, "_early_done"}, mem_done, 0);
    end
    mem_ack_i = 1'b1; mem_rdata_i = rdata;
    tick;
    mem_ack_i = 1'b0; mem_rdata_i = $urandom;
    chk({tag, "_done"}, mem_done, 1);
    chk({tag, "_req_drop"}, mem_req_o, 0);
    chk({tag, "_busy_done"}, mem_busy, 1);
`ifdef MC_DP_MISALIGN_EN
    chk({tag, "_err"}, mem_err, 0);
`endif
    tick;
    chk({tag, "_done_pulse"}, mem_done, 0);
    chk({tag, "_busy_end"}, mem_busy, 0);
    if (rd && !wr) m_mdr = rdata;
  endtask

  task automatic fetch(input logic [31:0] word);
    mem_xact(1'b1, 1'b0, 1'b0, word, $urandom_range(0, 2), m_pc, 32'h0, 1'b0, "fetch");
    ir_wr = 1'b1;
    tick;
    ir_wr = 1'b0;
    m_ir = m_mdr;
    chk("ir_op", op, m_ir[31:26]);
    chk("ir_funct", funct, m_ir[5:0]);
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
    fetch({6'h23, 5'd0, r, 16'h0000});
    mem_xact(1'b1, 1'b0, 1'b0, v, $urandom_range(0, 2), m_pc, 32'h0, 1'b0, "load");
    d_sel = D_MDR; r_sel = R_RT; rf_wr = 1'b1;
    tick;
    rf_wr = 1'b0;
    if (r != 5'd0) m_rf[r] = v;
  endtask

  // Store r0+0 <- rf[y]: the store data exposes the register contents.
  task automatic read_reg(input logic [4:0] y, input string tag);
    fetch({6'h2b, 5'd0, y, 16'h0000});
    alu_op = ALU_ADD; b_sel = 1'b1; ext_op = EXT_ZERO;
    tick; tick;
    mem_xact(1'b0, 1'b1, 1'b1, $urandom, $urandom_range(0, 2), 32'h0, m_rf[y], 1'b0, tag);
  endtask

  task automatic rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [3:0] f);
    logic [31:0] res;
    fetch({6'h00, rs, rt, rd, 5'd0, 6'h20});
    alu_op = f; b_sel = 1'b0;
    tick; tick;
    res = alu_ref(f, m_rf[rs], m_rf[rt]);
    chk("zero_flag", zero, res == 32'h0);
    d_sel = D_ALU; r_sel = R_RD; rf_wr = 1'b1;
    tick;
    rf_wr = 1'b0;
    if (rd != 5'd0) m_rf[rd] = res;
  endtask

  task automatic ext_test(input logic [15:0] imm, input logic [1:0] e);
    fetch({6'h0d, 5'd0, 5'd0, imm});
    alu_op = ALU_ADD; b_sel = 1'b1; ext_op = e;
    tick; tick;
    mem_xact(1'b0, 1'b1, 1'b1, $urandom, 0, ext_ref(imm, e), 32'h0, 1'b0, "ext");
  endtask

  task automatic set_pc(input logic [1:0] mode, input string tag);
    npc_op = mode; pc_wr = 1'b1;
    tick;
    pc_wr = 1'b0;
    case (mode)
      NPC_BR:  m_pc = m_pc + 32'd4 + {{14{m_ir[15]}}, m_ir[15:0], 2'b00};
      NPC_J:   m_pc = {m_pc[31:28], m_ir[25:0], 2'b00};
      NPC_JR:  m_pc = m_rf[m_ir[25:21]];
      default: m_pc = m_pc + 32'd4;
    endcase
    chk(tag, pc_o, m_pc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [8];
    logic [4:0] ra, rb, rdst;
    logic [15:0] imm;
    ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU};

    rst = 1'b1; pc_wr = 0; ir_wr = 0; rf_wr = 0; b_sel = 0; mem_rd = 0; mem_wr = 0;
    mem_src = 0; mem_ack_i = 0; npc_op = NPC_PC4; ext_op = EXT_ZERO; d_sel = D_ALU;
    r_sel = R_RT; alu_op = ALU_ADD; mem_rdata_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_pc", pc_o, m_pc);
    chk("rst_req", mem_req_o, 0);
    chk("rst_busy", mem_busy, 0);
    chk("rst_done", mem_done, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_op", op, 0);
    chk("rst_funct", funct, 0);
    read_reg(5'd1, "rst_r1");
    read_reg(5'd31, "rst_r31");

    // Fetch with ack held off three cycles
    mem_xact(1'b1, 1'b0, 1'b0, 32'h0022_1820, 3, m_pc, 32'h0, 1'b0, "fetch3");
    ir_wr = 1'b1; tick; ir_wr = 1'b0; m_ir = m_mdr;
    chk("fetch3_op", op, 6'h00);
    chk("fetch3_funct", funct, 6'h20);

    // Ack while idle must not disturb MDR
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF; tick; mem_ack_i = 1'b0;
    chk("idle_ack_done", mem_done, 0);
    ir_wr = 1'b1; tick; ir_wr = 1'b0; m_ir = m_mdr;
    chk("idle_ack_op", op, m_mdr[31:26]);

    // R-type add and write to r0
    write_reg(5'd1, 32'd5);
    write_reg(5'd2, 32'd7);
    rtype(5'd1, 5'd2, 5'd3, ALU_ADD);
    read_reg(5'd3, "add_r3");
    rtype(5'd1, 5'd2, 5'd0, ALU_ADD);
    read_reg(5'd0, "add_r0");

    // NPC modes
    fetch(32'h1000_FFFF);
    set_pc(NPC_BR, "npc_branch");
    npc_op = NPC_PC4; tick;
    chk("pc_hold", pc_o, m_pc);
    fetch(32'h0800_0C01);
    set_pc(NPC_J, "npc_jump");
    write_reg(5'd4, 32'h0000_3100);
    fetch(32'h0080_0008);
    tick;
    set_pc(NPC_JR, "npc_jr");
    set_pc(NPC_PC4, "npc_pc4");
    d_sel = D_PC; r_sel = R_LINK; rf_wr = 1'b1; tick; rf_wr = 1'b0;
    m_rf[31] = m_pc;
    read_reg(5'd31, "link_r31");

    // Extender modes
    for (int i = 0; i < 6; i++) begin
      imm = 16'($urandom);
`ifdef MC_DP_MISALIGN_EN
      imm[1:0] = 2'b00;
`endif
      ext_test(imm, 2'(i % 4));
    end

    // Random register-register operations
    for (int i = 0; i < 20; i++) begin
      ra = 5'($urandom_range(1, 31));
      rb = 5'($urandom_range(1, 31));
      rdst = 5'($urandom_range(0, 31));
      write_reg(ra, $urandom);
      write_reg(rb, (i % 5 == 0) ? m_rf[ra] : $urandom);
      rtype(ra, rb, rdst, ops[$urandom_range(0, 7)]);
      read_reg(rdst, "rand_rd");
    end

    // Simultaneous strobes: write wins, MDR untouched, strobes during REQ ignored
    mem_xact(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 2, m_pc, m_rf[m_ir[20:16]], 1'b1, "both");
    tick;
    chk("both_no_restart", mem_req_o, 0);
    chk("both_idle_busy", mem_busy, 0);
    ir_wr = 1'b1; tick; ir_wr = 1'b0; m_ir = m_mdr;
    chk("both_mdr_op", op, m_mdr[31:26]);
    chk("both_mdr_funct", funct, m_mdr[5:0]);

`ifdef MC_DP_MISALIGN_EN
    fetch({6'h23, 5'd0, 5'd0, 16'h1002});
    alu_op = ALU_ADD; b_sel = 1'b1; ext_op = EXT_ZERO;
    tick; tick;
    mem_rd = 1'b1; mem_src = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    tick;
    mem_rd = 1'b0;
    chk("mis_req", mem_req_o, 0);
    chk("mis_done", mem_done, 1);
    chk("mis_err", mem_err, 1);
    mem_ack_i = 1'b1; tick; mem_ack_i = 1'b0;
    chk("mis_req2", mem_req_o, 0);
    chk("mis_done_pulse", mem_done, 0);
    chk("mis_err_pulse", mem_err, 0);
    ir_wr = 1'b1; tick; ir_wr = 1'b0; m_ir = m_mdr;
    chk("mis_mdr_op", op, m_mdr[31:26]);
`endif

    // Reset in the middle of a request
    mem_rd = 1'b1; mem_src = 1'b0;
    tick;
    mem_rd = 1'b0;
    chk("abort_req_on", mem_req_o, 1);
    rst = 1'b1; tick; rst = 1'b0;
    model_reset();
    chk("abort_req_off", mem_req_o, 0);
    chk("abort_busy", mem_busy, 0);
    mem_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", mem_done, 0);
      tick;
      mem_ack_i = 1'b0;
    end
    chk("abort_pc", pc_o, m_pc);
    read_reg(5'd3, "abort_r3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
